load_align_unit: RTL and testbench

- Parametrised load-path successor to the core's combinational load-extension logic.
- Accepts one load request at a time: address, funct3 and destination register tag.
- Issues one or two XLEN-aligned memory reads, aligns and sign/zero-extends the result, and returns it with the tag.
- Handles loads that are misaligned inside a word and loads that cross a word boundary, or faults on them, depending on a parameter.
- Sits between the execute stage and the data memory/cache port.

---
 rtl/load_align_unit_if.sv | 41 ++++
 rtl/load_align_unit.sv | 166 ++++++++++++++++
 tb/tb_load_align_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Load request, data-memory read port and load-result channels of the load align unit.
interface load_align_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [4:0]        req_rd;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_fault;

    // Requester / memory / consumer side.
    modport master (
        output req_valid, req_addr, req_funct3, req_rd,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_ready,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  rsp_valid, rsp_data, rsp_rd, rsp_fault
    );

    // Load align unit side.
    modport slave (
        input  req_valid, req_addr, req_funct3, req_rd,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_ready,
        output req_ready, mem_req_valid, mem_req_addr,
        output rsp_valid, rsp_data, rsp_rd, rsp_fault
    );
endinterface

// File: rtl/load_align_unit.sv
// Load path: issues one or two aligned reads per load, then aligns and extends the result.
module load_align_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    load_align_unit_if.slave bus,
    output logic             busy
);
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned SH_W  = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              ready_q, mem_valid_q, rsp_valid_q, busy_q;

    // Request legality: unknown funct3, or natural misalignment when unsupported.
    logic       legal_c, misaligned_c, req_fault_c;
    logic [2:0] size_mask_c;
    always_comb begin
        legal_c = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
            3'b011, 3'b110:                         legal_c = (XLEN == 64);
            default:                                legal_c = 1'b0;
        endcase
        size_mask_c  = 3'((4'd1 << bus.req_funct3[1:0]) - 4'd1);
        misaligned_c = |(bus.req_addr[2:0] & size_mask_c);
        req_fault_c  = !legal_c || (!MISALIGN_EN && misaligned_c);
    end

    // Beat combining, byte alignment and sign/zero extension.
    logic [4:0]        span_c;
    logic              cross_c;
    logic [2*XLEN-1:0] beats_c;
    logic [XLEN-1:0]   raw_c, result_c;
    logic [6:0]        size_bits_c;
    logic [SH_W-1:0]   ext_sh_c;
    always_comb begin
        span_c      = 5'(off_q) + (5'd1 << funct3_q[1:0]);
        cross_c     = span_c > 5'(BYTES);
        beats_c     = (state_q == WAIT1) ? {bus.mem_rsp_data, lo_q}
                                         : {{XLEN{1'b0}}, bus.mem_rsp_data};
        raw_c       = XLEN'(beats_c >> {off_q, 3'b000});
        size_bits_c = 7'd8 << funct3_q[1:0];
        ext_sh_c    = '0;
        if (size_bits_c < 7'(XLEN)) begin
            ext_sh_c = SH_W'(7'(XLEN) - size_bits_c);
        end
        if (funct3_q[2]) begin
            result_c = (raw_c << ext_sh_c) >> ext_sh_c;
        end else begin
            result_c = XLEN'($signed(raw_c << ext_sh_c) >>> ext_sh_c);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        lo_d        = lo_q;
        mem_addr_d  = mem_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d      = bus.req_addr[OFF_W-1:0];
                    funct3_d   = bus.req_funct3;
                    rd_d       = bus.req_rd;
                    mem_addr_d = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    if (req_fault_c) begin
                        state_d     = RESP;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d     = REQ0;
                        rsp_fault_d = 1'b0;
                    end
                end
            end
            REQ0: begin
                if (bus.mem_req_ready) state_d = WAIT0;
            end
            WAIT0: begin
                if (bus.mem_rsp_valid) begin
                    lo_d = bus.mem_rsp_data;
                    if (cross_c) begin
                        state_d    = REQ1;
                        mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
                    end else begin
                        state_d    = RESP;
                        rsp_data_d = result_c;
                    end
                end
            end
            REQ1: begin
                if (bus.mem_req_ready) state_d = WAIT1;
            end
            WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    state_d    = RESP;
                    rsp_data_d = result_c;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registers; handshake outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            off_q       <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            lo_q        <= '0;
            mem_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            ready_q     <= 1'b1;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            lo_q        <= lo_d;
            mem_addr_q  <= mem_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            ready_q     <= (state_d == IDLE);
            mem_valid_q <= (state_d == REQ0) || (state_d == REQ1);
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Ready is additionally held low for as long as reset is asserted.
    assign bus.req_ready     = ready_q & rst_n;
    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_rd        = rd_q;
    assign bus.rsp_fault     = rsp_fault_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three configurations against a byte-level memory/load model.
module tb_load_align_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  rv;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic [4:0]  req_rd;
    logic        mem_req_ready, mem_rsp_valid, rsp_ready;
    logic [63:0] mem_rsp_data;
    logic [2:0]  busy;

    // 0: XLEN=32 misaligned allowed, 1: XLEN=32 strict, 2: XLEN=64 misaligned allowed
    load_align_unit_if #(.XLEN(32), .ADDR_W(32)) if_a ();
    load_align_unit_if #(.XLEN(32), .ADDR_W(32)) if_s ();
    load_align_unit_if #(.XLEN(64), .ADDR_W(32)) if_w ();

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a), .busy(busy[0]));
    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s), .busy(busy[1]));
    load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w), .busy(busy[2]));

    assign if_a.req_valid = rv[0];
    assign if_s.req_valid = rv[1];
    assign if_w.req_valid = rv[2];
    assign if_a.req_addr = req_addr;  assign if_s.req_addr = req_addr;  assign if_w.req_addr = req_addr;
    assign if_a.req_funct3 = req_f3;  assign if_s.req_funct3 = req_f3;  assign if_w.req_funct3 = req_f3;
    assign if_a.req_rd = req_rd;      assign if_s.req_rd = req_rd;      assign if_w.req_rd = req_rd;
    assign if_a.mem_req_ready = mem_req_ready; assign if_s.mem_req_ready = mem_req_ready; assign if_w.mem_req_ready = mem_req_ready;
    assign if_a.mem_rsp_valid = mem_rsp_valid; assign if_s.mem_rsp_valid = mem_rsp_valid; assign if_w.mem_rsp_valid = mem_rsp_valid;
    assign if_a.mem_rsp_data = mem_rsp_data[31:0];
    assign if_s.mem_rsp_data = mem_rsp_data[31:0];
    assign if_w.mem_rsp_data = mem_rsp_data;
    assign if_a.rsp_ready = rsp_ready; assign if_s.rsp_ready = rsp_ready; assign if_w.rsp_ready = rsp_ready;

    int          sel;
    logic        t_req_ready, t_mreq_valid, t_rsp_valid, t_rsp_fault, t_busy;
    logic [31:0] t_mreq_addr;
    logic [63:0] t_rsp_data;
    logic [4:0]  t_rsp_rd;
    always_comb begin
        t_req_ready = if_a.req_ready; t_mreq_valid = if_a.mem_req_valid; t_mreq_addr = if_a.mem_req_addr;
        t_rsp_valid = if_a.rsp_valid; t_rsp_data = {32'h0, if_a.rsp_data}; t_rsp_rd = if_a.rsp_rd;
        t_rsp_fault = if_a.rsp_fault; t_busy = busy[0];
        if (sel == 1) begin
            t_req_ready = if_s.req_ready; t_mreq_valid = if_s.mem_req_valid; t_mreq_addr = if_s.mem_req_addr;
            t_rsp_valid = if_s.rsp_valid; t_rsp_data = {32'h0, if_s.rsp_data}; t_rsp_rd = if_s.rsp_rd;
            t_rsp_fault = if_s.rsp_fault; t_busy = busy[1];
        end else if (sel == 2) begin
            t_req_ready = if_w.req_ready; t_mreq_valid = if_w.mem_req_valid; t_mreq_addr = if_w.mem_req_addr;
            t_rsp_valid = if_w.rsp_valid; t_rsp_data = if_w.rsp_data; t_rsp_rd = if_w.rsp_rd;
            t_rsp_fault = if_w.rsp_fault; t_busy = busy[2];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: overridden words, otherwise an address hash.
    logic [63:0] ovr [logic [31:0]];

    function automatic int xl_of(input int s);
        return (s == 2) ? 64 : 32;
    endfunction

    function automatic logic [63:0] mem_word(input int xl, input logic [31:0] a);
        logic [31:0] al;
        logic [63:0] w;
        al = a & ~32'(xl / 8 - 1);
        if (ovr.exists(al)) w = ovr[al];
        else w = {al * 32'h9E37_79B1, (al ^ 32'h5BD1_E995) * 32'h85EB_CA6B};
        if (xl == 32) w[63:32] = '0;
        return w;
    endfunction

    function automatic logic [7:0] mem_byte(input int xl, input logic [31:0] a);
        int off;
        off = int'(a % 32'(xl / 8));
        return 8'(mem_word(xl, a) >> (8 * off));
    endfunction

    // Reference: gather the addressed bytes little-endian, then extend.
    function automatic void ref_load(input int xl, input bit mis, input logic [31:0] a, input logic [2:0] f3,
                                     output logic [63:0] d, output bit flt, output int n,
                                     output logic [31:0] a0, output logic [31:0] a1);
        int  bytes, size, off;
        bit  legal;
        bytes = xl / 8;
        size  = 1 << f3[1:0];
        off   = int'(a % 32'(bytes));
        legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (xl == 64 && (f3 inside {3'd3, 3'd6}));
        flt   = !legal || (!mis && (a % 32'(size)) != 32'd0);
        a0    = a - 32'(off);
        a1    = a0 + 32'(bytes);
        d     = '0;
        n     = 0;
        if (flt) return;
        n = (off + size > bytes) ? 2 : 1;
        for (int i = 0; i < size; i++) d = d | (64'(mem_byte(xl, a + 32'(i))) << (8 * i));
        if (!f3[2] && ((d >> (8 * size - 1)) & 64'd1) == 64'd1) d = d | ~((64'd1 << (8 * size)) - 64'd1);
        if (xl == 32) d[63:32] = '0;
    endfunction

    // Memory responder: optional ready stalls, delayed responses, stray response pulses.
    int          pend = 0, extra_min = 0, extra_max = 0, stall_left = 0;
    bit          rnd_ready = 0, junk_en = 0, prev_stall = 0;
    logic [31:0] pend_addr, held_addr;
    logic [31:0] req_log [$];

    initial begin
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(xl_of(sel), pend_addr);
                end
            end else if (junk_en && $urandom_range(0, 2) == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = {$urandom, $urandom};
            end
            if (t_mreq_valid && prev_stall) check_eq("mreq_addr_hold", 64'(t_mreq_addr), 64'(held_addr));
            if (t_mreq_valid && stall_left > 0) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_stall = t_mreq_valid && !mem_req_ready;
            held_addr  = t_mreq_addr;
            if (t_mreq_valid && mem_req_ready) begin
                req_log.push_back(t_mreq_addr);
                pend      = 1 + int'($urandom_range(extra_min, extra_max));
                pend_addr = t_mreq_addr;
            end
        end
    end

    task automatic issue(input int s, input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         output bit ok);
        int n;
        sel      = s;
        req_addr = addr;
        req_f3   = f3;
        req_rd   = rd;
        rv       = '0;
        rv[s]    = 1'b1;
        #1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            ok = t_req_ready;
            @(negedge clk);
            n++;
        end
        rv = '0;
        if (!ok) check_eq("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_load(input int s, input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input int hold, input bit chk_lat, output logic [63:0] got);
        logic [63:0] e_d, d0;
        bit          e_f, ok, f0;
        int          e_n, n;
        logic [31:0] e_a0, e_a1;
        logic [4:0]  r0;
        ref_load(xl_of(s), s != 1, addr, f3, e_d, e_f, e_n, e_a0, e_a1);
        req_log.delete();
        rsp_ready = (hold == 0);
        issue(s, addr, f3, rd, ok);
        n = 1;
        while (!t_rsp_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_valid", 64'(t_rsp_valid), 64'd1);
        if (chk_lat) check_eq("latency", 64'(n), e_f ? 64'd1 : (e_n == 2 ? 64'd5 : 64'd3));
        check_eq("rsp_fault", 64'(t_rsp_fault), 64'(e_f));
        check_eq("rsp_data", t_rsp_data, e_d);
        check_eq("rsp_rd", 64'(t_rsp_rd), 64'(rd));
        check_eq("mem_req_count", 64'(req_log.size()), 64'(e_n));
        if (e_n > 0 && req_log.size() > 0) check_eq("mem_addr0", 64'(req_log[0]), 64'(e_a0));
        if (e_n > 1 && req_log.size() > 1) check_eq("mem_addr1", 64'(req_log[1]), 64'(e_a1));
        d0 = t_rsp_data;
        r0 = t_rsp_rd;
        f0 = t_rsp_fault;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(t_rsp_valid), 64'd1);
            check_eq("hold_data", t_rsp_data, d0);
            check_eq("hold_rd_fault", {58'd0, f0, r0}, {58'd0, t_rsp_fault, t_rsp_rd});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("rsp_drop", 64'(t_rsp_valid), 64'd0);
        got = d0;
    endtask

    task automatic fast_mode();
        rnd_ready = 0; junk_en = 0; extra_min = 0; extra_max = 0;
    endtask

    logic [63:0] got;
    logic [31:0] ra;
    logic [2:0]  rf;
    int          rs, n;
    bit          ok, fast;

    initial begin
        rst_n = 1'b0; rv = '0; req_addr = '0; req_f3 = '0; req_rd = '0; rsp_ready = 1'b1; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_eq("rst_req_ready", 64'(t_req_ready), 64'd0);
            check_eq("rst_busy", 64'(t_busy), 64'd0);
            check_eq("rst_rsp_valid", 64'(t_rsp_valid), 64'd0);
            check_eq("rst_mem_valid", 64'(t_mreq_valid), 64'd0);
            check_eq("rst_rsp", {t_rsp_data[62:0], t_rsp_fault} | 64'(t_rsp_rd), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_req_ready", 64'(t_req_ready), 64'd1);

        fast_mode();
        ovr[32'h100] = 64'h8012_3456;
        ovr[32'h200] = 64'hAABB_CCDD;
        ovr[32'h204] = 64'h1122_3344;
        do_load(0, 32'h103, 3'b000, 5'd3, 0, 1, got);
        check_eq("lb_0x103", got, 64'h0000_0000_FFFF_FF80);
        do_load(0, 32'h203, 3'b101, 5'd4, 0, 1, got);
        check_eq("lhu_0x203", got, 64'h0000_0000_0000_44AA);

        do_load(1, 32'h302, 3'b010, 5'd5, 0, 1, got);
        check_eq("strict_lw_fault_data", got, 64'd0);
        do_load(1, 32'h300, 3'b111, 5'd6, 0, 1, got);
        do_load(0, 32'h300, 3'b111, 5'd7, 0, 1, got);
        do_load(1, 32'h300, 3'b010, 5'd8, 0, 1, got);
        do_load(0, 32'h203, 3'b011, 5'd9, 0, 1, got);

        stall_left = 4;
        do_load(0, 32'h106, 3'b001, 5'd17, 3, 0, got);

        do_load(0, 32'hFFFF_FFFE, 3'b010, 5'd10, 0, 1, got);

        // Reset while the second beat of a crossing load is outstanding.
        extra_min = 3; extra_max = 3;
        req_log.delete();
        issue(0, 32'hFFFF_FFFE, 3'b010, 5'd11, ok);
        n = 0;
        while (req_log.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait1_reached", 64'(req_log.size()), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 64'(t_busy), 64'd0);
        check_eq("midrst_req_ready", 64'(t_req_ready), 64'd0);
        check_eq("midrst_mem_valid", 64'(t_mreq_valid), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("late_rsp_ignored", {62'd0, t_rsp_valid, t_busy}, 64'd0);
        end
        fast_mode();
        do_load(0, 32'h104, 3'b010, 5'd12, 0, 1, got);

        ovr[32'h1000] = 64'h89AB_CDEF_0000_0000;
        ovr[32'h1008] = 64'h0000_0000_7654_3210;
        ovr[32'h2000] = 64'h0000_0000_F000_0000;
        do_load(2, 32'h1004, 3'b011, 5'd13, 0, 1, got);
        check_eq("ld_0x1004", got, 64'h7654_3210_89AB_CDEF);
        do_load(2, 32'h2000, 3'b110, 5'd14, 0, 1, got);
        check_eq("lwu_64", got, 64'h0000_0000_F000_0000);
        do_load(2, 32'h2000, 3'b010, 5'd15, 0, 1, got);
        check_eq("lw_64_sext", got, 64'hFFFF_FFFF_F000_0000);

        for (int i = 0; i < 200; i++) begin
            rs = int'($urandom_range(0, 2));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ra[1:0] = 2'b00;
            rf   = 3'($urandom_range(0, 7));
            fast = ($urandom_range(0, 3) == 0);
            rnd_ready = !fast;
            junk_en   = !fast;
            extra_min = 0;
            extra_max = fast ? 0 : 3;
            do_load(rs, ra, rf, 5'($urandom), fast ? 0 : int'($urandom_range(0, 2)), fast, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
